// File: rtl/unified_mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Port ids double as indices into the two-bit request vector.
package unified_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_MEM_LAT = 1;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
// Purely combinational; the caller owns the last-grant register.
module mem_arb_rr2
  import unified_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = PORT_IF;
    if (req == 2'b11) begin
      grant_id = ~last;
    end else if (req[PORT_LS]) begin
      grant_id = PORT_LS;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one memory between instruction fetch (IF) and load/store (LS) ports.
// IDLE grants, ACCESS drives the memory for MEM_LAT cycles, RESP pulses ack.
//
// Handshake: a port raises req with we/addr/wdata stable and holds it until
// its one-cycle ack; it must drop req (or present a new request) the cycle
// after ack. rdata/err are valid with ack; rdata holds until the next ack.
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic              if_we,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [DATA_W-1:0] if_wdata,
  output logic              if_ack,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic              ls_err,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int                CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  arb_state_e        state, state_next;
  logic              port_q, we_q, err_q, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              gnt_valid, gnt_id;
  logic              sel_we, addr_bad;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  mem_arb_rr2 u_rr (
    .req         ({ls_req, if_req}),
    .last        (last_q),
    .grant_valid (gnt_valid),
    .grant_id    (gnt_id)
  );

  assign sel_we    = (gnt_id == PORT_LS) ? ls_we    : if_we;
  assign sel_addr  = (gnt_id == PORT_LS) ? ls_addr  : if_addr;
  assign sel_wdata = (gnt_id == PORT_LS) ? ls_wdata : if_wdata;
  assign addr_bad  = {1'b0, sel_addr} >= DEPTH_LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (gnt_valid) state_next = addr_bad ? RESP : ACCESS;
      ACCESS:  if (cnt_q == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q   <= PORT_IF;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      last_q   <= PORT_IF;
      if_rdata <= '0;
      ls_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            port_q  <= gnt_id;
            we_q    <= sel_we;
            err_q   <= addr_bad;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt_q   <= CNT_INIT;
            // Out-of-range reads bypass the memory and return zero.
            if (addr_bad && !sel_we) begin
              if (gnt_id == PORT_LS) ls_rdata <= '0;
              else                   if_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!we_q) begin
            if (port_q == PORT_LS) ls_rdata <= mem_rdata;
            else                   if_rdata <= mem_rdata;
          end
        end
        RESP:    last_q <= port_q;
        default: ;
      endcase
    end
  end

  // Memory controls decode only state and latched registers, so an async
  // reset removes them immediately and req never reaches the memory directly.
  assign mem_read  = (state == ACCESS) && !we_q;
  assign mem_write = (state == ACCESS) && we_q && (cnt_q == CNT_INIT);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_ack    = (state == RESP) && (port_q == PORT_IF);
  assign ls_ack    = (state == RESP) && (port_q == PORT_LS);
  assign if_err    = if_ack && err_q;
  assign ls_err    = ls_ack && err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a MEM_LAT=1 instance with a small
// memory model, plus a MEM_LAT=3 instance fed by a fixed address pattern.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        if_req, if_we, ls_req, ls_we;
  logic [31:0] if_addr, if_wdata, ls_addr, ls_wdata;
  logic        if_ack, if_err, ls_ack, ls_err;
  logic [31:0] if_rdata, ls_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  logic        t3_if_req;
  logic [31:0] t3_if_addr;
  logic        t3_if_ack, t3_if_err, t3_ls_ack, t3_ls_err;
  logic [31:0] t3_if_rdata, t3_ls_rdata;
  logic        t3_mem_read, t3_mem_write;
  logic [31:0] t3_mem_addr, t3_mem_wdata, t3_mem_rdata;
  logic [1:0]  t3_dbg_state;

  logic [31:0] mem [64];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_wdata(if_wdata),
    .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_err(ls_err), .ls_rdata(ls_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  unified_mem_arbiter #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(t3_if_req), .if_we(1'b0), .if_addr(t3_if_addr), .if_wdata(32'd0),
    .if_ack(t3_if_ack), .if_err(t3_if_err), .if_rdata(t3_if_rdata),
    .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'd0), .ls_wdata(32'd0),
    .ls_ack(t3_ls_ack), .ls_err(t3_ls_err), .ls_rdata(t3_ls_rdata),
    .mem_read(t3_mem_read), .mem_write(t3_mem_write), .mem_addr(t3_mem_addr),
    .mem_wdata(t3_mem_wdata), .mem_rdata(t3_mem_rdata), .dbg_state(t3_dbg_state)
  );

  assign mem_rdata    = mem[mem_addr[5:0]];
  assign t3_mem_rdata = 32'hC0DE_0000 | t3_mem_addr;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises one request in IDLE, waits (bounded) for its ack, then releases req.
  task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int nrd,
                         output int nwr, output int nother, output logic [31:0] rdata,
                         output logic err, output logic seen);
    if (port) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_we = we; if_addr = addr; if_wdata = wdata;
    end
    lat = 0; nrd = 0; nwr = 0; nother = 0; rdata = '0; err = 1'b0; seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      if (c > 1) tick();
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (port ? if_ack : ls_ack) nother++;
      if (port ? ls_ack : if_ack) begin
        seen  = 1'b1;
        lat   = c;
        rdata = port ? ls_rdata : if_rdata;
        err   = port ? ls_err : if_err;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();
  endtask

  initial begin
    int          lat, nrd, nwr, nother, nack, nbad;
    logic [31:0] rdata;
    logic        err, seen;

    if_req = 0; if_we = 0; if_addr = 0; if_wdata = 0;
    ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    t3_if_req = 0; t3_if_addr = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[4] = 32'h0253_9820;

    repeat (2) tick();
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    check("rst_ctrl", {28'b0, if_ack, ls_ack, mem_read, mem_write}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_rdata", if_rdata | ls_rdata, 32'd0);
    rst_n = 1'b1;

    run_txn(1'b0, 1'b0, 32'd4, 32'd0, lat, nrd, nwr, nother, rdata, err, seen);
    check("if_rd_seen", {31'b0, seen}, 32'd1);
    check("if_rd_lat", 32'(lat), 32'd3);
    check("if_rd_nrd", 32'(nrd), 32'd1);
    check("if_rd_nwr", 32'(nwr), 32'd0);
    check("if_rd_ls_ack", 32'(nother), 32'd0);
    check("if_rd_data", rdata, 32'h0253_9820);
    check("if_rd_err", {31'b0, err}, 32'd0);

    run_txn(1'b1, 1'b1, 32'd18, 32'h22, lat, nrd, nwr, nother, rdata, err, seen);
    check("ls_wr_lat", 32'(lat), 32'd3);
    check("ls_wr_nwr", 32'(nwr), 32'd1);
    check("ls_wr_nrd", 32'(nrd), 32'd0);
    check("ls_wr_mem", mem[18], 32'h22);
    check("ls_wr_rdata_kept", ls_rdata, 32'd0);

    run_txn(1'b1, 1'b0, 32'd18, 32'd0, lat, nrd, nwr, nother, rdata, err, seen);
    check("ls_rd_lat", 32'(lat), 32'd3);
    check("ls_rd_data", rdata, 32'h22);
    check("if_rdata_held", if_rdata, 32'h0253_9820);

    run_txn(1'b1, 1'b0, 32'd64, 32'd0, lat, nrd, nwr, nother, rdata, err, seen);
    check("ls_oob_lat", 32'(lat), 32'd2);
    check("ls_oob_err", {31'b0, err}, 32'd1);
    check("ls_oob_data", rdata, 32'd0);
    check("ls_oob_mem_act", 32'(nrd + nwr), 32'd0);

    run_txn(1'b0, 1'b1, 32'd200, 32'h77, lat, nrd, nwr, nother, rdata, err, seen);
    check("if_oob_wr_lat", 32'(lat), 32'd2);
    check("if_oob_wr_err", {31'b0, err}, 32'd1);
    check("if_oob_wr_nwr", 32'(nwr), 32'd0);
    check("if_oob_wr_rdata", if_rdata, 32'h0253_9820);

    // Reset in the middle of an LS write.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'd20; ls_wdata = 32'h55;
    tick();
    check("mid_rst_wr_on", {31'b0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wr_off", {30'b0, mem_read, mem_write}, 32'd0);
    check("mid_rst_addr", mem_addr | mem_wdata, 32'd0);
    check("mid_rst_rdata", if_rdata | ls_rdata, 32'd0);
    check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
    ls_req = 1'b0;
    nack = 0;
    repeat (2) begin
      tick();
      if (if_ack || ls_ack) nack++;
    end
    rst_n = 1'b1;
    tick();
    if (if_ack || ls_ack) nack++;
    check("mid_rst_no_ack", 32'(nack), 32'd0);
    check("mid_rst_mem", mem[20], 32'hA000_0014);

    // Both ports hold req from a fresh reset: LS wins first, then alternate.
    exp_q = '{{1'b1, 31'd3}, {1'b0, 31'd6}, {1'b1, 31'd9}, {1'b0, 31'd12}};
    if_req = 1'b1; if_we = 1'b0; if_addr = 32'd4;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd5;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      if (if_ack && ls_ack) check("tie_dual_ack", 32'd1, 32'd0);
      else if (if_ack || ls_ack) begin
        if (exp_q.size() == 0) check("tie_extra_ack", 32'(c), 32'd0);
        else check("tie_ack", {ls_ack, 31'(c)}, exp_q.pop_front());
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    check("tie_all_acks", 32'(exp_q.size()), 32'd0);
    check("tie_if_data", if_rdata, 32'h0253_9820);
    check("tie_ls_data", ls_rdata, 32'hA000_0005);
    tick();

    // MEM_LAT = 3 instance.
    t3_if_req = 1'b1; t3_if_addr = 32'd7;
    lat = 0; nrd = 0; nbad = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      if (c > 1) tick();
      if (t3_mem_read) begin
        nrd++;
        if (t3_mem_addr != 32'd7) nbad++;
      end
      if (t3_mem_write) nbad++;
      if (t3_if_ack) lat = c;
    end
    t3_if_req = 1'b0;
    check("lat3_ack_cycle", 32'(lat), 32'd5);
    check("lat3_nrd", 32'(nrd), 32'd3);
    check("lat3_addr_stable", 32'(nbad), 32'd0);
    check("lat3_data", t3_if_rdata, 32'hC0DE_0007);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates the single shared instruction/data memory of the multi-cycle MIPS core between two requesters: the instruction-fetch port (IF) and the load/store port (LS). It grants one requester at a time with two-way round-robin fairness, drives the memory's read/write controls for a fixed access latency, and returns registered read data with a one-cycle acknowledge. It sits between the core's multi-cycle control unit and the memory array.

## Interface
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width
- DEPTH, 64, number of memory words; valid addresses are 0..DEPTH-1
- MEM_LAT, 1, memory access cycles per transaction (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req, ls_req  in  1  request, held until the matching ack
- if_we, ls_we  in  1  1 = write, 0 = read
- if_addr, ls_addr  in  ADDR_W  word index, passed to memory unchanged
- if_wdata, ls_wdata  in  DATA_W  write data
- if_ack, ls_ack  out  1  one-cycle completion pulse
- if_err, ls_err  out  1  valid with ack; address ≥ DEPTH
- if_rdata, ls_rdata  out  DATA_W  read result; valid with ack and held until the next ack to the same port
- mem_read, mem_write  out  1  memory read/write enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational memory read data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: sample if_req and ls_req.
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the port not granted last. The last-grant bit resets to IF, so LS wins the first tie.
  - On grant, latch the port id, we, addr and wdata. Set access counter to MEM_LAT-1. Go to ACCESS.
  - If the latched addr ≥ DEPTH: set err, skip ACCESS and go to RESP directly with no memory activity.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers.
  - mem_read = !we for all ACCESS cycles.
  - mem_write = we in the first ACCESS cycle only, so exactly one write edge occurs.
  - Counter decrements each cycle. On the cycle where counter = 0, capture mem_rdata into the granted port's rdata register (reads only) and go to RESP.
- RESP: pulse the granted port's ack for one cycle; err is valid in the same cycle. Update the last-grant bit. Go to IDLE.
- Writes leave rdata unchanged. Errored reads load rdata with 0.
- Requester rule: deassert req (or present a new request) in the cycle after ack. A req high in IDLE is always treated as a new request.
- The non-granted requester waits with req held. Round-robin bounds its wait to one transaction.

## Timing
- Reset values: state IDLE, all acks/errs 0, mem_read/mem_write 0, mem_addr/mem_wdata 0, rdata registers 0, last-grant = IF.
- Latency from req high in IDLE to ack: 1 + MEM_LAT + 1 cycles (3 at default). Errored access: 2 cycles.
- Back-to-back throughput: one transaction per MEM_LAT+2 cycles.
- mem_* outputs are registered or decoded only from state and latched registers. There are no combinational paths from req inputs to memory controls.
- Reset asserted mid-transaction: mem_write/mem_read drop immediately (asynchronously). A write not yet clocked is not performed. No ack is issued. Requesters must re-request after reset.
- Simultaneous req edges in the RESP cycle are ignored until IDLE.

## Structure
- Package unified_mem_arb_pkg holds:
  - the state enum (IDLE/ACCESS/RESP);
  - port-id constants PORT_IF = 0, PORT_LS = 1;
  - default parameter values.
- Sub-module mem_arb_rr2: combinational two-way round-robin picker. Inputs: req[1:0], last. Outputs: grant_valid, grant_id.
- The top holds the FSM, latency counter, latch registers and rdata registers.

## Test plan
- Single IF read, addr 4, memory word 0x02539820 → mem_read high exactly 1 cycle, if_ack on cycle 3 with if_rdata = 0x02539820, ls_ack stays 0.
- LS write addr 18, wdata 0x22 → mem_write high exactly one cycle, ls_ack cycle 3; a following LS read of addr 18 returns 0x22.
- Both requesting continuously from reset → grants alternate LS, IF, LS, IF; ack spacing 3 cycles; neither port waits more than one transaction.
- LS read addr 64 (DEPTH) → ls_ack and ls_err on cycle 2, ls_rdata = 0, mem_read/mem_write never asserted.
- MEM_LAT = 3, IF read → mem_read high 3 cycles, mem_addr stable, ack on cycle 5.
- rst_n low during ACCESS of an LS write → mem_write falls immediately, no ack, target word unchanged; all outputs at reset values.
